// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register file write-port arbiter for pipeline/multi-cycle results
// plus the scoreboard of registers awaiting a multi-cycle result.
module rf_wb_arbiter #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int MAX_WAIT = 4,
  parameter int WCNT_W   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_a_we,
  input  logic [4:0]      i_a_rd,
  input  logic [XLEN-1:0] i_a_wd,
  output logic            o_stall_a,
  input  logic            i_b_valid,
  input  logic [4:0]      i_b_rd,
  input  logic [XLEN-1:0] i_b_wd,
  output logic            o_b_ready,
  input  logic            i_iss_valid,
  input  logic [4:0]      i_iss_rd,
  input  logic [4:0]      i_chk_rs1,
  input  logic [4:0]      i_chk_rs2,
  input  logic [4:0]      i_chk_rd,
  output logic            o_hazard,
  output logic            o_rf_we,
  output logic [4:0]      o_rf_rd,
  output logic [XLEN-1:0] o_rf_wd,
  output logic [NREG-1:0] o_busy_vec
);

  logic [WCNT_W-1:0] r_wait_cnt;
  logic [NREG-1:0]   r_busy;

  logic            w_a_req;
  logic            w_b_req;
  logic            w_b_x0;
  logic            w_starve;
  logic            w_grant_a;
  logic            w_grant_b;
  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_eff;

  assign w_a_req   = i_a_we & (i_a_rd != 5'd0);
  assign w_b_req   = i_b_valid & (i_b_rd != 5'd0);
  assign w_b_x0    = i_b_valid & (i_b_rd == 5'd0);
  assign w_starve  = (r_wait_cnt == WCNT_W'(MAX_WAIT));
  assign w_grant_b = w_b_req & (w_starve | ~w_a_req);
  assign w_grant_a = w_a_req & ~w_grant_b;

  assign w_clr = NREG'(w_grant_b) << i_b_rd;
  assign w_set = NREG'(i_iss_valid && (i_iss_rd != 5'd0)) << i_iss_rd;
  // A result landing this cycle is forwarded by the register file, so it no longer blocks issue.
  assign w_eff = r_busy & ~w_clr;

  assign o_b_ready  = rst_n & (w_grant_b | w_b_x0);
  assign o_stall_a  = rst_n & w_starve & w_b_req & w_a_req;
  assign o_hazard   = rst_n & (w_eff[i_chk_rs1] | w_eff[i_chk_rs2] | w_eff[i_chk_rd]);
  assign o_busy_vec = r_busy;

  always_comb begin
    o_rf_we = 1'b0;
    o_rf_rd = 5'd0;
    o_rf_wd = '0;
    if (rst_n) begin
      if (w_grant_b) begin
        o_rf_we = 1'b1;
        o_rf_rd = i_b_rd;
        o_rf_wd = i_b_wd;
      end else if (w_grant_a) begin
        o_rf_we = 1'b1;
        o_rf_rd = i_a_rd;
        o_rf_wd = i_a_wd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
      r_busy     <= '0;
    end else begin
      if (!w_b_req || w_grant_b)
        r_wait_cnt <= '0;
      else if (!w_starve)
        r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
      // Set is applied after clear so a same-cycle reissue keeps the register busy.
      r_busy <= ((r_busy & ~w_clr) | w_set) & ~NREG'(1);
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - scoreboard bench for rf_wb_arbiter
`timescale 1ns/1ps
module tb_rf_wb_arbiter;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int S_WE = 0, S_RD = 1, S_WD = 2, S_BRDY = 3, S_STALL = 4, S_HAZ = 5, S_BUSY = 6;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            a_we = 1'b0;
  logic [4:0]      a_rd = 5'd0;
  logic [XLEN-1:0] a_wd = '0;
  logic            b_valid = 1'b0;
  logic [4:0]      b_rd = 5'd0;
  logic [XLEN-1:0] b_wd = '0;
  logic            iss_valid = 1'b0;
  logic [4:0]      iss_rd = 5'd0;
  logic [4:0]      chk_rs1 = 5'd0;
  logic [4:0]      chk_rs2 = 5'd0;
  logic [4:0]      chk_rd = 5'd0;
  logic            stall_a, b_ready, hazard, rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wd;
  logic [NREG-1:0] busy_vec;

  rf_wb_arbiter #(.XLEN(XLEN), .NREG(NREG), .MAX_WAIT(4), .WCNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_a_we(a_we), .i_a_rd(a_rd), .i_a_wd(a_wd), .o_stall_a(stall_a),
    .i_b_valid(b_valid), .i_b_rd(b_rd), .i_b_wd(b_wd), .o_b_ready(b_ready),
    .i_iss_valid(iss_valid), .i_iss_rd(iss_rd),
    .i_chk_rs1(chk_rs1), .i_chk_rs2(chk_rs2), .i_chk_rd(chk_rd), .o_hazard(hazard),
    .o_rf_we(rf_we), .o_rf_rd(rf_rd), .o_rf_wd(rf_wd), .o_busy_vec(busy_vec)
  );

  always #10 clk = ~clk;

  typedef struct {
    int          sel;
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      S_WE:    return 64'(rf_we);
      S_RD:    return 64'(rf_rd);
      S_WD:    return 64'(rf_wd);
      S_BRDY:  return 64'(b_ready);
      S_STALL: return 64'(stall_a);
      S_HAZ:   return 64'(hazard);
      default: return 64'(busy_vec);
    endcase
  endfunction

  task automatic push_exp(input int sel, input string tag, input logic [63:0] v);
    exp_t e;
    e.sel = sel;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic push_wr(input string tag, input logic we, input logic [4:0] rd, input logic [XLEN-1:0] wd);
    push_exp(S_WE, {tag, "_we"}, 64'(we));
    push_exp(S_RD, {tag, "_rd"}, 64'(rd));
    push_exp(S_WD, {tag, "_wd"}, 64'(wd));
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic settle();
    #3;
    drain();
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset with a pending A write
    a_we = 1'b1; a_rd = 5'd3;
    next(); next();
    push_wr("rst", 1'b0, 5'd0, '0);
    push_exp(S_BUSY, "rst_busy", 64'd0);
    push_exp(S_HAZ, "rst_haz", 64'd0);
    push_exp(S_BRDY, "rst_brdy", 64'd0);
    settle();

    next();
    rst_n = 1'b1; a_wd = 32'h55;
    push_wr("rel", 1'b1, 5'd3, 32'h55);
    settle();

    // contention: B refused four cycles, then forced through
    next();
    b_valid = 1'b1; b_rd = 5'd7; b_wd = 32'hDEAD;
    a_we = 1'b1; a_rd = 5'd5; a_wd = 32'h11;
    for (int c = 0; c < 4; c++) begin
      push_wr($sformatf("cont%0d", c), 1'b1, 5'd5, 32'h11);
      push_exp(S_BRDY, $sformatf("cont%0d_brdy", c), 64'd0);
      push_exp(S_STALL, $sformatf("cont%0d_stall", c), 64'd0);
      settle();
      next();
    end
    push_wr("starve", 1'b1, 5'd7, 32'hDEAD);
    push_exp(S_BRDY, "starve_brdy", 64'd1);
    push_exp(S_STALL, "starve_stall", 64'd1);
    settle();
    next();
    b_valid = 1'b0;
    push_wr("after", 1'b1, 5'd5, 32'h11);
    push_exp(S_STALL, "after_stall", 64'd0);
    push_exp(S_BRDY, "after_brdy", 64'd0);
    settle();

    // scoreboard set / same-cycle clear
    next();
    a_we = 1'b0; iss_valid = 1'b1; iss_rd = 5'd9;
    push_exp(S_BUSY, "iss9_pre", 64'd0);
    settle();
    next();
    iss_valid = 1'b0; chk_rs2 = 5'd9;
    push_exp(S_BUSY, "iss9_busy", 64'(32'h1 << 9));
    push_exp(S_HAZ, "iss9_haz", 64'd1);
    settle();
    next();
    b_valid = 1'b1; b_rd = 5'd9; b_wd = 32'h99;
    push_exp(S_HAZ, "b9_fwd_haz", 64'd0);
    push_exp(S_BRDY, "b9_brdy", 64'd1);
    push_wr("b9", 1'b1, 5'd9, 32'h99);
    settle();
    next();
    b_valid = 1'b0;
    push_exp(S_BUSY, "b9_clr", 64'd0);
    push_exp(S_HAZ, "b9_haz", 64'd0);
    settle();

    // set/clear collision on r12
    next();
    chk_rs2 = 5'd0; chk_rd = 5'd12; iss_valid = 1'b1; iss_rd = 5'd12;
    settle();
    next();
    b_valid = 1'b1; b_rd = 5'd12; b_wd = 32'hC;
    push_exp(S_BRDY, "col_brdy", 64'd1);
    push_exp(S_HAZ, "col_haz", 64'd0);
    settle();
    next();
    iss_valid = 1'b0; b_valid = 1'b0;
    push_exp(S_BUSY, "col_busy", 64'(32'h1 << 12));
    push_exp(S_HAZ, "col_haz_after", 64'd1);
    settle();
    next();
    b_valid = 1'b1;
    settle();
    next();
    b_valid = 1'b0; chk_rd = 5'd0;
    push_exp(S_BUSY, "r12_clr", 64'd0);
    settle();

    // x0 handling
    next();
    iss_valid = 1'b1; iss_rd = 5'd0;
    b_valid = 1'b1; b_rd = 5'd0; b_wd = 32'hBAD;
    a_we = 1'b1; a_rd = 5'd4; a_wd = 32'h44;
    push_exp(S_BRDY, "bx0_brdy", 64'd1);
    push_exp(S_STALL, "bx0_stall", 64'd0);
    push_wr("bx0", 1'b1, 5'd4, 32'h44);
    settle();
    next();
    iss_valid = 1'b0;
    a_rd = 5'd0; b_rd = 5'd6; b_wd = 32'h66;
    push_exp(S_BUSY, "iss0_busy", 64'd0);
    push_wr("ax0", 1'b1, 5'd6, 32'h66);
    push_exp(S_BRDY, "ax0_brdy", 64'd1);
    push_exp(S_STALL, "ax0_stall", 64'd0);
    settle();

    // build wait_cnt = 3 and busy[9], then asynchronous reset mid-cycle
    next();
    iss_valid = 1'b1; iss_rd = 5'd9;
    a_we = 1'b1; a_rd = 5'd5; a_wd = 32'h11;
    b_valid = 1'b1; b_rd = 5'd7; b_wd = 32'hDEAD;
    next();
    iss_valid = 1'b0;
    next(); next();
    chk_rs1 = 5'd9;
    push_exp(S_BRDY, "pre_brdy", 64'd0);
    push_exp(S_HAZ, "pre_haz", 64'd1);
    push_exp(S_BUSY, "pre_busy", 64'(32'h1 << 9));
    push_wr("pre", 1'b1, 5'd5, 32'h11);
    settle();
    #1 rst_n = 1'b0;
    push_wr("mid", 1'b0, 5'd0, '0);
    push_exp(S_BRDY, "mid_brdy", 64'd0);
    push_exp(S_STALL, "mid_stall", 64'd0);
    push_exp(S_HAZ, "mid_haz", 64'd0);
    push_exp(S_BUSY, "mid_busy", 64'd0);
    #2 drain();
    next(); next();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      push_exp(S_BRDY, $sformatf("re%0d_brdy", c), 64'd0);
      push_exp(S_RD, $sformatf("re%0d_rd", c), 64'd5);
      settle();
      next();
    end
    push_exp(S_BRDY, "re4_brdy", 64'd1);
    push_exp(S_STALL, "re4_stall", 64'd1);
    push_exp(S_RD, "re4_rd", 64'd7);
    settle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Write-port controller and scoreboard for the 32x32 register file (single write port, write on negedge, same-cycle write-to-read forwarding). It shares the one write port between two requesters. A is the in-order pipeline writeback. B is the multi-cycle unit result (mul/div/FPU), which uses a valid/ready handshake. It also tracks registers with in-flight multi-cycle results and raises a hazard to the issue stage.

Parameters:
XLEN, 32, data width
NREG, 32, number of architectural registers; register 0 is hardwired zero
MAX_WAIT, 4, consecutive cycles B may be refused before A is stalled (legal range 1..7)
WCNT_W, 3, width of the wait counter; must satisfy 2^WCNT_W > MAX_WAIT

Ports:
clk  in  1  clock; state updates on posedge
rst_n  in  1  reset, asynchronous, active-low
a_we  in  1  pipeline writeback request
a_rd  in  5  pipeline destination register
a_wd  in  XLEN  pipeline write data
stall_a  out  1  pipeline must hold writeback and re-present it next cycle
b_valid  in  1  multi-cycle result valid
b_rd  in  5  multi-cycle destination register
b_wd  in  XLEN  multi-cycle write data
b_ready  out  1  B result accepted this cycle
iss_valid  in  1  multi-cycle op issued this cycle
iss_rd  in  5  destination register of the issued op
chk_rs1, chk_rs2, chk_rd  in  5 each  operands of the instruction in issue
hazard  out  1  instruction in issue must stall
rf_we  out  1  register file write enable
rf_rd  out  5  register file write address
rf_wd  out  XLEN  register file write data
busy_vec  out  NREG  scoreboard bits; bit 0 is always 0

Behaviour:
- Internal definitions:
  - a_req = a_we & (a_rd != 0).
  - b_req = b_valid & (b_rd != 0).
  - starve = (wait_cnt == MAX_WAIT).
- Grant decision is combinational, with zero latency from inputs to rf_* outputs. State is wait_cnt and busy[NREG-1:1].
- Grant rules, evaluated in order:
  - starve & b_req: grant B; stall_a = a_req; A's write is dropped this cycle.
  - a_req: grant A; b_ready = 0.
  - b_req: grant B.
  - Otherwise no write.
- B with b_rd == 0: b_ready = b_valid with no write. This is never blocked and needs no port.
- Outputs per grant:
  - Grant A: rf_we = 1, rf_rd = a_rd, rf_wd = a_wd.
  - Grant B: rf_we = 1, rf_rd = b_rd, rf_wd = b_wd, b_ready = 1.
  - No grant: rf_we = 0, rf_rd = 0, rf_wd = 0.
- stall_a is asserted only in the starve cycle. It is never asserted when b_req = 0.
- wait_cnt update at posedge:
  - Cleared to 0 if !b_req or B is granted.
  - Otherwise increments, saturating at MAX_WAIT.
- Scoreboard update at posedge:
  - busy[iss_rd] is set if iss_valid & iss_rd != 0.
  - busy[b_rd] is cleared on a B handshake with b_rd != 0.
  - Same register set and cleared in the same cycle: the set wins.
  - iss_valid to an already-busy register: the bit stays set.
- hazard = eff[chk_rs1] | eff[chk_rs2] | eff[chk_rd], where eff = busy with bit b_rd masked on a B handshake this cycle. This matches the register file's same-cycle forwarding. eff[0] = 0.
- A and B targeting the same rd in one cycle cannot occur under correct issue. If it does, the normal grant rules apply and B retries.
- Reset (rst_n low, asynchronous):
  - wait_cnt = 0 and busy = 0 immediately.
  - While rst_n is low, all outputs are forced to 0: rf_we, rf_rd, rf_wd, b_ready, stall_a, hazard.
  - On release, arbitration restarts from wait_cnt = 0. In-flight B results are not preserved.

Test Plan:
- Reset: rst_n low with a_we = 1, a_rd = 3 -> rf_we = 0, busy_vec = 0, hazard = 0. After release with a_wd = 0x55 -> rf_we = 1, rf_rd = 3, rf_wd = 0x55.
- Contention (MAX_WAIT = 4): b_valid = 1, b_rd = 7, b_wd = 0xDEAD held; a_we = 1, a_rd = 5 every cycle.
  - Cycles 0-3: rf_rd = 5, b_ready = 0.
  - Cycle 4: stall_a = 1, b_ready = 1, rf_rd = 7, rf_wd = 0xDEAD.
  - Cycle 5 (b_valid dropped): rf_rd = 5, stall_a = 0.
- Scoreboard: iss_valid = 1, iss_rd = 9 -> next cycle busy_vec[9] = 1 and chk_rs2 = 9 gives hazard = 1. B handshake with b_rd = 9 -> hazard = 0 in the same cycle; busy_vec[9] = 0 next cycle.
- Set/clear collision: B handshake on rd = 12 while iss_valid with iss_rd = 12 -> busy_vec[12] = 1 afterwards.
- x0 handling:
  - iss_rd = 0 -> busy_vec unchanged.
  - b_valid with b_rd = 0 while a_we, a_rd = 4 -> b_ready = 1, rf_rd = 4, stall_a = 0.
  - a_we with a_rd = 0 plus b_rd = 6 -> B granted immediately.
- Mid-operation reset: wait_cnt = 3, busy[9] = 1, pull rst_n low mid-cycle -> outputs 0 with no clock edge. After release with contention restarted, B is granted only on the 5th cycle.
